// File: rtl/uart_rx_frame_pkg.sv
// Shared UART constants and receiver state encoding (also used by the transmitter).
package uart_pkg;
   localparam int OVERSAMPLE = 16;
   localparam int MID_TICK   = 7;
   localparam int LAST_TICK  = OVERSAMPLE - 1;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      STOP   = 3'd3,
      PARITY = 3'd4
   } state_t;
endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit, reset to RST_VAL.
module sync_2ff #(
   parameter logic RST_VAL = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);
   logic r_meta;
   logic r_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_meta <= RST_VAL;
         r_q    <= RST_VAL;
      end else begin
         r_meta <= d;
         r_q    <= r_meta;
      end
   end

   assign q = r_q;
endmodule

// File: rtl/uart_rx_frame.sv
// 16x-oversampled UART receiver: start/data/stop framing with mid-bit sampling.
// Optional parity stage and parity_err port when UART_RX_PARITY_EN is defined.
module uart_rx_frame
   import uart_pkg::*;
#(
   parameter int DBIT    = 8,
   parameter int SB_TICK = 16,
   parameter int PAR_ODD = 0
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            s_tick,
   input  logic            rx,
   output logic [DBIT-1:0] rx_dout,
   output logic            rx_done_tick,
`ifdef UART_RX_PARITY_EN
   output logic            parity_err,
`endif
   output logic            frame_err
);
   localparam int SW = ($clog2(SB_TICK) > 4) ? $clog2(SB_TICK) : 4;
   localparam int NW = $clog2(DBIT);

   state_t          r_state, w_state_n;
   logic [SW-1:0]   r_s, w_s_n;
   logic [NW-1:0]   r_n, w_n_n;
   logic [DBIT-1:0] r_b, w_b_n;
   logic [DBIT-1:0] r_dout, w_dout_n;
   logic            r_done, w_done_n;
   logic            r_ferr, w_ferr_n;
   logic            w_perr_cur;
   logic            w_perr_pulse;
   logic            w_rxs;

   sync_2ff #(.RST_VAL(1'b1)) u_sync (
      .clk (clk),
      .rst (rst),
      .d   (rx),
      .q   (w_rxs)
   );

`ifdef UART_RX_PARITY_EN
   logic r_perr, w_perr_n;
   logic r_perr_out;
   assign w_perr_cur = r_perr;
`else
   logic w_unused_par;
   assign w_unused_par = PAR_ODD[0];
   assign w_perr_cur   = 1'b0;
`endif

   always_comb begin
      w_state_n    = r_state;
      w_s_n        = r_s;
      w_n_n        = r_n;
      w_b_n        = r_b;
      w_dout_n     = r_dout;
      w_done_n     = 1'b0;
      w_ferr_n     = 1'b0;
      w_perr_pulse = 1'b0;
`ifdef UART_RX_PARITY_EN
      w_perr_n     = r_perr;
`endif
      case (r_state)
         // Level-sensitive start detect: a held-low line counts as a start.
         IDLE: if (!w_rxs) begin
            w_s_n     = '0;
            w_state_n = START;
         end
         START: if (s_tick) begin
            if (r_s == SW'(MID_TICK)) begin
               if (!w_rxs) begin
                  w_s_n     = '0;
                  w_n_n     = '0;
                  w_state_n = DATA;
               end else begin
                  w_state_n = IDLE;
               end
            end else begin
               w_s_n = r_s + 1'b1;
            end
         end
         DATA: if (s_tick) begin
            if (r_s == SW'(LAST_TICK)) begin
               w_s_n = '0;
               w_b_n = {w_rxs, r_b[DBIT-1:1]};
               if (r_n == NW'(DBIT-1)) begin
`ifdef UART_RX_PARITY_EN
                  w_state_n = PARITY;
`else
                  w_state_n = STOP;
`endif
               end else begin
                  w_n_n = r_n + 1'b1;
               end
            end else begin
               w_s_n = r_s + 1'b1;
            end
         end
`ifdef UART_RX_PARITY_EN
         PARITY: if (s_tick) begin
            if (r_s == SW'(LAST_TICK)) begin
               w_perr_n  = ((^r_b) ^ w_rxs) != PAR_ODD[0];
               w_s_n     = '0;
               w_state_n = STOP;
            end else begin
               w_s_n = r_s + 1'b1;
            end
         end
`endif
         STOP: if (s_tick) begin
            if (r_s == SW'(SB_TICK-1)) begin
               if (w_rxs && !w_perr_cur) begin
                  w_dout_n = r_b;
                  w_done_n = 1'b1;
               end
               w_ferr_n     = !w_rxs;
               w_perr_pulse = w_perr_cur;
               w_state_n    = IDLE;
            end else begin
               w_s_n = r_s + 1'b1;
            end
         end
         default: w_state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= IDLE;
         r_s     <= '0;
         r_n     <= '0;
         r_b     <= '0;
         r_dout  <= '0;
         r_done  <= 1'b0;
         r_ferr  <= 1'b0;
      end else begin
         r_state <= w_state_n;
         r_s     <= w_s_n;
         r_n     <= w_n_n;
         r_b     <= w_b_n;
         r_dout  <= w_dout_n;
         r_done  <= w_done_n;
         r_ferr  <= w_ferr_n;
      end
   end

`ifdef UART_RX_PARITY_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_perr     <= 1'b0;
         r_perr_out <= 1'b0;
      end else begin
         r_perr     <= w_perr_n;
         r_perr_out <= w_perr_pulse;
      end
   end
   assign parity_err = r_perr_out;
`else
   logic w_unused_pulse;
   assign w_unused_pulse = w_perr_pulse;
`endif

   assign rx_dout      = r_dout;
   assign rx_done_tick = r_done;
   assign frame_err    = r_ferr;
endmodule

// File: tb/tb_uart_rx_frame.sv
// Self-checking bench for uart_rx_frame: s_tick every 4 clk, 64 clk per bit.
`timescale 1ns/1ps
module tb_uart_rx_frame;
   localparam int DBIT = 8;
   localparam int BIT_CLK = 64;

   logic            clk = 1'b0;
   logic            rst = 1'b0;
   logic            s_tick = 1'b0;
   logic            rx = 1'b1;
   logic [DBIT-1:0] rx_dout;
   logic            rx_done_tick;
   logic            frame_err;
`ifdef UART_RX_PARITY_EN
   logic            parity_err;
   logic            par_flip = 1'b0;
   int              n_perr = 0;
`endif

   int  total = 0;
   int  bad   = 0;
   int  n_done = 0;
   int  n_ferr = 0;
   logic [DBIT-1:0] last_dout = '0;
   time t_done  = 0;
   time t_start = 0;
   int  tcnt = 0;
   logic [DBIT-1:0] exp_dout = '0;

   uart_rx_frame #(.DBIT(DBIT), .SB_TICK(16), .PAR_ODD(0)) dut (
      .clk          (clk),
      .rst          (rst),
      .s_tick       (s_tick),
      .rx           (rx),
      .rx_dout      (rx_dout),
      .rx_done_tick (rx_done_tick),
`ifdef UART_RX_PARITY_EN
      .parity_err   (parity_err),
`endif
      .frame_err    (frame_err)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      tcnt   = (tcnt + 1) % 4;
      s_tick = (tcnt == 0);
   end

   always @(negedge clk) begin
      if (rx_done_tick) begin
         n_done++;
         last_dout = rx_dout;
         t_done    = $time;
      end
      if (frame_err) n_ferr++;
`ifdef UART_RX_PARITY_EN
      if (parity_err) n_perr++;
`endif
   end

   task automatic idle(input int clks);
      rx = 1'b1;
      repeat (clks) @(negedge clk);
   endtask

   // stop_len < BIT_CLK shortens a low stop bit so the trailing low doesn't look like a real start.
   task automatic send_frame(input logic [DBIT-1:0] d, input logic stop_lvl, input int stop_len);
      @(negedge clk);
      rx = 1'b0;
      t_start = $time;
      repeat (BIT_CLK) @(negedge clk);
      for (int i = 0; i < DBIT; i++) begin
         rx = d[i];
         repeat (BIT_CLK) @(negedge clk);
      end
`ifdef UART_RX_PARITY_EN
      rx = (^d) ^ par_flip;
      repeat (BIT_CLK) @(negedge clk);
`endif
      rx = stop_lvl;
      repeat (stop_len) @(negedge clk);
      rx = 1'b1;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      repeat (5) @(negedge clk);
      total++; if (rx_dout !== '0) begin bad++; $display("FAIL reset_dout got=%h want=0", rx_dout); end
      total++; if (rx_done_tick !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", rx_done_tick); end
      total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL reset_ferr got=%b want=0", frame_err); end
      rst = 1'b1;
      idle(20);
   endtask

   task automatic test_single();
      int d0, f0;
      time lat;
      d0 = n_done; f0 = n_ferr;
      send_frame(8'hA5, 1'b1, BIT_CLK);
      idle(20);
      exp_dout = 8'hA5;
      total++; if (n_done - d0 != 1) begin bad++; $display("FAIL a5_done_cnt got=%0d want=1", n_done - d0); end
      total++; if (rx_dout !== exp_dout) begin bad++; $display("FAIL a5_dout got=%h want=%h", rx_dout, exp_dout); end
      total++; if (n_ferr != f0) begin bad++; $display("FAIL a5_ferr got=%0d want=0", n_ferr - f0); end
      // 9.5 bits after the start edge = 608 clk
      lat = (t_done - t_start) / 10;
      total++; if (lat < 604 || lat > 612) begin bad++; $display("FAIL a5_latency got=%0d want=608+-4", lat); end
   endtask

   task automatic test_back_to_back();
      int d0, f0;
      d0 = n_done; f0 = n_ferr;
      send_frame(8'h00, 1'b1, BIT_CLK);
      total++; if (last_dout !== 8'h00) begin bad++; $display("FAIL b2b_first got=%h want=00", last_dout); end
      send_frame(8'hFF, 1'b1, BIT_CLK);
      idle(20);
      exp_dout = 8'hFF;
      total++; if (n_done - d0 != 2) begin bad++; $display("FAIL b2b_done_cnt got=%0d want=2", n_done - d0); end
      total++; if (rx_dout !== exp_dout) begin bad++; $display("FAIL b2b_second got=%h want=%h", rx_dout, exp_dout); end
      total++; if (n_ferr != f0) begin bad++; $display("FAIL b2b_ferr got=%0d want=0", n_ferr - f0); end
   endtask

   task automatic test_glitch();
      int d0, f0;
      d0 = n_done; f0 = n_ferr;
      @(negedge clk);
      rx = 1'b0;
      repeat (12) @(negedge clk);
      idle(200);
      total++; if (n_done != d0 || n_ferr != f0) begin bad++; $display("FAIL glitch_pulses got=%0d/%0d want=0/0", n_done - d0, n_ferr - f0); end
      total++; if (rx_dout !== exp_dout) begin bad++; $display("FAIL glitch_dout got=%h want=%h", rx_dout, exp_dout); end
   endtask

   task automatic test_frame_err();
      int d0, f0;
      d0 = n_done; f0 = n_ferr;
      send_frame(8'h3C, 1'b0, 40);
      idle(200);
      total++; if (n_ferr - f0 != 1) begin bad++; $display("FAIL ferr_cnt got=%0d want=1", n_ferr - f0); end
      total++; if (n_done != d0) begin bad++; $display("FAIL ferr_done got=%0d want=0", n_done - d0); end
      total++; if (rx_dout !== exp_dout) begin bad++; $display("FAIL ferr_dout got=%h want=%h", rx_dout, exp_dout); end
   endtask

   task automatic test_reset_mid();
      int d0, f0;
      logic [DBIT-1:0] p;
      p = 8'h55;
      @(negedge clk);
      rx = 1'b0;
      repeat (BIT_CLK) @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         rx = p[i];
         repeat (BIT_CLK) @(negedge clk);
      end
      rst = 1'b0;
      @(negedge clk);
      rx = 1'b1;
      exp_dout = '0;
      total++; if (rx_dout !== exp_dout || rx_done_tick !== 1'b0 || frame_err !== 1'b0) begin
         bad++; $display("FAIL midrst_outputs got=%h/%b/%b want=0/0/0", rx_dout, rx_done_tick, frame_err);
      end
      repeat (5) @(negedge clk);
      rst = 1'b1;
      idle(100);
      d0 = n_done; f0 = n_ferr;
      send_frame(8'h81, 1'b1, BIT_CLK);
      idle(20);
      exp_dout = 8'h81;
      total++; if (n_done - d0 != 1) begin bad++; $display("FAIL midrst_done_cnt got=%0d want=1", n_done - d0); end
      total++; if (rx_dout !== exp_dout) begin bad++; $display("FAIL midrst_dout got=%h want=%h", rx_dout, exp_dout); end
      total++; if (n_ferr != f0) begin bad++; $display("FAIL midrst_ferr got=%0d want=0", n_ferr - f0); end
   endtask

   task automatic test_random();
      int d0, f0;
      logic [DBIT-1:0] d;
      logic good;
      for (int k = 0; k < 8; k++) begin
         d    = DBIT'($urandom);
         good = ($urandom_range(0, 3) != 0);
         d0 = n_done; f0 = n_ferr;
         send_frame(d, good, good ? BIT_CLK : 40);
         idle(good ? 20 : 200);
         if (good) exp_dout = d;
         total++; if (n_done - d0 != (good ? 1 : 0)) begin bad++; $display("FAIL rand%0d_done got=%0d want=%0d", k, n_done - d0, good ? 1 : 0); end
         total++; if (n_ferr - f0 != (good ? 0 : 1)) begin bad++; $display("FAIL rand%0d_ferr got=%0d want=%0d", k, n_ferr - f0, good ? 0 : 1); end
         total++; if (rx_dout !== exp_dout) begin bad++; $display("FAIL rand%0d_dout got=%h want=%h", k, rx_dout, exp_dout); end
      end
   endtask

`ifdef UART_RX_PARITY_EN
   task automatic test_parity();
      int d0, p0;
      d0 = n_done; p0 = n_perr;
      par_flip = 1'b0;
      send_frame(8'h07, 1'b1, BIT_CLK);
      idle(20);
      exp_dout = 8'h07;
      total++; if (n_done - d0 != 1 || n_perr != p0) begin bad++; $display("FAIL par_good got=%0d/%0d want=1/0", n_done - d0, n_perr - p0); end
      total++; if (rx_dout !== exp_dout) begin bad++; $display("FAIL par_good_dout got=%h want=%h", rx_dout, exp_dout); end
      d0 = n_done; p0 = n_perr;
      par_flip = 1'b1;
      send_frame(8'h07, 1'b1, BIT_CLK);
      idle(20);
      par_flip = 1'b0;
      total++; if (n_done != d0 || n_perr - p0 != 1) begin bad++; $display("FAIL par_bad got=%0d/%0d want=0/1", n_done - d0, n_perr - p0); end
      total++; if (rx_dout !== exp_dout) begin bad++; $display("FAIL par_bad_dout got=%h want=%h", rx_dout, exp_dout); end
   endtask
`endif

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_glitch();
      test_frame_err();
      test_reset_mid();
      test_random();
`ifdef UART_RX_PARITY_EN
      test_parity();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
